// File: rtl/addsub_arbiter_if.sv
// Handshake bundle between the two operation sources, the shared add/sub
// arbiter and the result consumer.
interface addsub_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_a;
  logic [2:0] req0_b;
  logic       req0_opt;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_a;
  logic [2:0] req1_b;
  logic       req1_opt;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_id;

  // Source/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_opt,
    output req1_valid, req1_a, req1_b, req1_opt,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_opt,
    input  req1_valid, req1_a, req1_b, req1_opt,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 3-bit add/sub core between two requesters,
// with a one-entry registered result slot tagged by the issuing requester.

// 3-bit operands, 4-bit result; subtract is A + ~B + 1 in 4-bit two's complement.
module addsub_core (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       opt,
  output logic [3:0] result
);
  logic [3:0] b_ext;

  assign b_ext  = opt ? {1'b1, ~b} : {1'b0, b};
  assign result = {1'b0, a} + b_ext + {3'b000, opt};
endmodule

module addsub_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  addsub_arbiter_if.slave bus
);
  logic       prio;
  logic       out_valid_q;
  logic [3:0] out_data_q;
  logic       out_id_q;

  logic       slot_free;
  logic       grant0;
  logic       grant1;
  logic [2:0] sel_a;
  logic [2:0] sel_b;
  logic       sel_opt;
  logic [3:0] core_result;

  // The slot accepts a new result when empty or when it drains this cycle.
  assign slot_free = ~out_valid_q | bus.out_ready;

  // Gating with rst_n keeps both readys low for the whole reset window.
  assign grant0 = rst_n & slot_free & bus.req0_valid & (~prio | ~bus.req1_valid);
  assign grant1 = rst_n & slot_free & bus.req1_valid & ( prio | ~bus.req0_valid);

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    sel_a   = bus.req0_a;
    sel_b   = bus.req0_b;
    sel_opt = bus.req0_opt;
    if (grant1) begin
      sel_a   = bus.req1_a;
      sel_b   = bus.req1_b;
      sel_opt = bus.req1_opt;
    end
  end

  addsub_core u_core (
    .a      (sel_a),
    .b      (sel_b),
    .opt    (sel_opt),
    .result (core_result)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_id_q    <= 1'b0;
      prio        <= PRIO_RESET;
    end else if (grant0 | grant1) begin
      out_valid_q <= 1'b1;
      out_data_q  <= core_result;
      out_id_q    <= grant1;
      prio        <= ~grant1;   // priority passes to the other requester, idle or not
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vector table, alternation,
// backpressure and reset corners, and a randomized exhaustive sweep.
module tb_addsub_arbiter;
  localparam bit PRIO_RESET = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_arbiter_if bus ();

  addsub_arbiter #(.PRIO_RESET(PRIO_RESET)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       id;
    logic [3:0] data;
  } res_t;

  typedef struct {
    logic       id;
    logic [2:0] a;
    logic [2:0] b;
    logic       opt;
    logic [3:0] exp;
  } vec_t;

  res_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rx0     = 0;
  int   rx1     = 0;
  logic prio_m  = PRIO_RESET;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_result(input logic [2:0] a, input logic [2:0] b, input logic opt);
    int r;
    r = opt ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return r[3:0];
  endfunction

  // Observes one cycle at the falling edge: grant rules, result pops, request pushes.
  task automatic sb_sample();
    logic slot_free, e0, e1;
    res_t e;
    slot_free = !bus.out_valid || bus.out_ready;
    e0 = rst_n && slot_free && bus.req0_valid && (!prio_m || !bus.req1_valid);
    e1 = rst_n && slot_free && bus.req1_valid && ( prio_m || !bus.req0_valid);
    check("grant", 32'({bus.req0_ready, bus.req1_ready}), 32'({e0, e1}));
    if (!rst_n) begin
      sb_q.delete();
      prio_m = PRIO_RESET;
      return;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h, expected no result at %0t",
                 bus.out_id, bus.out_data, $time);
      end else begin
        e = sb_q.pop_front();
        check("result", 32'({bus.out_id, bus.out_data}), 32'({e.id, e.data}));
        if (e.id) rx1++;
        else      rx0++;
      end
    end
    if (bus.req0_valid && bus.req0_ready) begin
      sb_q.push_back(res_t'({1'b0, ref_result(bus.req0_a, bus.req0_b, bus.req0_opt)}));
      prio_m = 1'b1;
    end else if (bus.req1_valid && bus.req1_ready) begin
      sb_q.push_back(res_t'({1'b1, ref_result(bus.req1_a, bus.req1_b, bus.req1_opt)}));
      prio_m = 1'b0;
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    sb_sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_neg();
    to_pos();
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = 3'd0; bus.req0_b = 3'd0; bus.req0_opt = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = 3'd0; bus.req1_b = 3'd0; bus.req1_opt = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;   // a pending request must still see ready=0 in reset
    bus.req1_valid = 1'b1;
    cycle();
    to_neg();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_id",    32'(bus.out_id),    32'd0);
    check("rst_readys",    32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    to_pos();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [6];
    logic [3:0] alt_exp [4];
    logic       g0, g1, done;
    int         j0, j1, i0, i1, base0, base1;
    logic [6:0] op;

    vecs[0] = '{1'b0, 3'd3, 3'd5, 1'b0, 4'b1000};
    vecs[1] = '{1'b1, 3'd2, 3'd5, 1'b1, 4'b1101};
    vecs[2] = '{1'b0, 3'd7, 3'd7, 1'b0, 4'b1110};
    vecs[3] = '{1'b1, 3'd0, 3'd7, 1'b1, 4'b1001};
    vecs[4] = '{1'b0, 3'd7, 3'd0, 1'b1, 4'b0111};
    vecs[5] = '{1'b1, 3'd0, 3'd0, 1'b0, 4'b0000};
    alt_exp = '{4'd2, 4'd6, 4'd4, 4'd5};

    clear_inputs();
    to_pos();
    apply_reset();

    // Single requester vectors, including the range edges
    for (int v = 0; v < 6; v++) begin
      bus.out_ready = 1'b1;
      if (vecs[v].id) begin
        bus.req1_valid = 1'b1; bus.req1_a = vecs[v].a; bus.req1_b = vecs[v].b; bus.req1_opt = vecs[v].opt;
      end else begin
        bus.req0_valid = 1'b1; bus.req0_a = vecs[v].a; bus.req0_b = vecs[v].b; bus.req0_opt = vecs[v].opt;
      end
      to_neg();
      check("tbl_ready", 32'({bus.req0_ready, bus.req1_ready}), vecs[v].id ? 32'd1 : 32'd2);
      to_pos();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      to_neg();
      check("tbl_out_valid", 32'(bus.out_valid), 32'd1);
      check("tbl_out_data",  32'(bus.out_data),  32'(vecs[v].exp));
      check("tbl_out_id",    32'(bus.out_id),    32'(vecs[v].id));
      to_pos();
    end

    // Both requesters valid every cycle: grants alternate from PRIO_RESET
    apply_reset();
    bus.out_ready = 1'b1;
    j0 = 0;
    j1 = 0;
    for (int k = 0; k < 5; k++) begin
      bus.req0_valid = (j0 < 2);
      bus.req0_a = (j0 == 0) ? 3'd1 : 3'd2;
      bus.req0_b = (j0 == 0) ? 3'd1 : 3'd2;
      bus.req0_opt = 1'b0;
      bus.req1_valid = (j1 < 2);
      bus.req1_a = (j1 == 0) ? 3'd7 : 3'd6;
      bus.req1_b = 3'd1;
      bus.req1_opt = 1'b1;
      to_neg();
      if (k < 4)
        check("alt_ready", 32'({bus.req0_ready, bus.req1_ready}), (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k > 0) begin
        check("alt_out_valid", 32'(bus.out_valid), 32'd1);
        check("alt_out_data",  32'(bus.out_data),  32'(alt_exp[k-1]));
        check("alt_out_id",    32'(bus.out_id),    32'((k - 1) % 2));
      end
      g0 = bus.req0_valid && bus.req0_ready;
      g1 = bus.req1_valid && bus.req1_ready;
      to_pos();
      if (g0) j0++;
      if (g1) j1++;
    end
    clear_inputs();
    cycle();

    // Backpressure with result 6 pending from requester 1
    apply_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 3'd7; bus.req1_b = 3'd1; bus.req1_opt = 1'b1;
    to_neg();
    check("bp_first_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd1);
    to_pos();
    bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd1; bus.req0_opt = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 3'd2; bus.req1_b = 3'd2; bus.req1_opt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg();
      check("bp_readys",    32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data",  32'(bus.out_data),  32'b0110);
      check("bp_out_id",    32'(bus.out_id),    32'd1);
      to_pos();
    end
    bus.out_ready = 1'b1;
    to_neg();
    check("bp_release_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd2);
    to_pos();
    bus.req0_valid = 1'b0;
    bus.out_ready  = 1'b0;
    to_neg();
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_data",  32'(bus.out_data),  32'd2);
    check("bp_next_id",    32'(bus.out_id),    32'd0);

    // Reset while a result is held and backpressured
    to_pos();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    to_neg();
    check("mid_rst_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    to_pos();
    to_neg();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    to_pos();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    to_neg();
    check("post_rst_tie", 32'({bus.req0_ready, bus.req1_ready}), 32'd2);
    to_pos();
    clear_inputs();
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Exhaustive sweep with random valid and out_ready patterns
    base0 = rx0;
    base1 = rx1;
    i0 = 0;
    i1 = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (i0 == 128 && i1 == 128 && sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      if (!bus.req0_valid && i0 < 128 && $urandom_range(3) != 0) begin
        op = 7'(i0);
        bus.req0_a = op[2:0]; bus.req0_b = op[5:3]; bus.req0_opt = op[6];
        bus.req0_valid = 1'b1;
      end
      if (!bus.req1_valid && i1 < 128 && $urandom_range(3) != 0) begin
        op = 7'(127 - i1);
        bus.req1_a = op[2:0]; bus.req1_b = op[5:3]; bus.req1_opt = op[6];
        bus.req1_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      to_neg();
      g0 = bus.req0_valid && bus.req0_ready;
      g1 = bus.req1_valid && bus.req1_ready;
      to_pos();
      if (g0) begin bus.req0_valid = 1'b0; i0++; end
      if (g1) begin bus.req1_valid = 1'b0; i1++; end
    end
    check("sweep_done", 32'(done), 32'd1);
    check("sweep_rx0",  32'(rx0 - base0), 32'd128);
    check("sweep_rx1",  32'(rx1 - base1), 32'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter that shares one 3-bit add/subtract datapath (4-bit result; add is unsigned, subtract is 4-bit two's complement) between two requesters. Each requester presents an operand pair and an opcode on a valid/ready handshake. The block grants at most one request per cycle, computes the result through a single internal add/sub core, and holds it in a one-entry output register with its own valid/ready handshake and an owner tag. It sits between two operation sources and one shared result consumer.

## Interface
- PRIO_RESET, 0 — requester that holds priority after reset (0 or 1)
- clk  in  1  — single clock, rising edge
- rst_n  in  1  — synchronous, active-low reset, sampled on rising clk
- req0_valid  in  1  — requester 0 has an operation
- req0_ready  out  1  — requester 0's operation is accepted this cycle
- req0_a  in  3  — requester 0 operand A, unsigned
- req0_b  in  3  — requester 0 operand B, unsigned
- req0_opt  in  1  — requester 0 opcode: 0 = A+B, 1 = A−B
- req1_valid, req1_ready, req1_a, req1_b, req1_opt — same as requester 0, for requester 1
- out_valid  out  1  — result register holds a result
- out_ready  in  1  — consumer takes the result this cycle
- out_data  out  4  — result
- out_id  out  1  — requester that issued the result

## Operation
- Datapath: one combinational add/sub core, instantiated once and fed by a mux on the granted requester.
  - opt=0: out = {1'b0,A} + {1'b0,B}. Range 0..14, no overflow.
  - opt=1: out = A + {1'b1,~B} + 1 (mod 16) = A−B in 4-bit two's complement. Range −7..+7, no overflow.
- Slot free: `slot_free = ~out_valid | out_ready`.
- Priority register `prio` (1 bit) names the requester that wins a tie.
- Grant rules:
  - grant0 = slot_free & req0_valid & (prio==0 | ~req1_valid)
  - grant1 = slot_free & req1_valid & (prio==1 | ~req0_valid)
  - reqN_ready = grantN. At most one grant per cycle.
  - reqN_ready depends combinationally on out_ready and both valids. No requester may wait on its own ready before raising valid.
- On the clock edge after a grant to requester i:
  - out_data ← core result, out_id ← i, out_valid ← 1
  - prio ← ~i. Priority passes to the other requester even when it was idle.
- No grant and out_valid & out_ready: out_valid ← 0. out_data and out_id keep their values (don't-care).
- No grant and out_valid & ~out_ready: out_valid, out_data and out_id hold exactly.
- Requester side: reqN_a, reqN_b and reqN_opt must stay stable while reqN_valid=1 and reqN_ready=0. The block does not latch unaccepted operands.
- Reset (rst_n=0 at a rising edge): out_valid←0, out_data←0, out_id←0, prio←PRIO_RESET. While rst_n=0, req0_ready=req1_ready=0.
- Reset mid-operation: any result held in the output register is discarded and never presented.

## Timing
- Latency: request accepted at edge N (valid & ready high in the cycle before N) → out_valid=1 with its data from edge N.
- Throughput: one result per cycle while out_ready=1 and requests are pending. A drain and a new grant in the same cycle give a bubble-free stream.
- Backpressure: out_valid=1 & out_ready=0 → both reqN_ready=0 in that cycle.
- Both valids every cycle with out_ready=1: grants alternate each cycle, starting with PRIO_RESET after reset.
- Single active requester: granted every cycle. prio toggles to the idle requester after each grant.
- Outputs out_valid, out_data and out_id are registered. req*_ready is combinational.

## Test plan
- Reset, then req0 {a=3, b=5, opt=0} alone → req0_ready=1 in that cycle. Next cycle: out_valid=1, out_data=4'b1000, out_id=0.
- req1 {a=2, b=5, opt=1} → out_data=4'b1101 (−3), out_id=1. Edge values:
  - 7+7 → 4'b1110
  - 0−7 → 4'b1001
  - 7−0 → 4'b0111
  - 0+0 → 4'b0000
- Both valid continuously, out_ready=1, PRIO_RESET=0:
  - out_id sequence 0,1,0,1…, one result per cycle
  - req0 ops {1+1, 2+2} and req1 ops {7−1, 6−1} → out_data 2, 6, 4, 5
- Backpressure: hold out_ready=0 with result 4'b0110 pending and both requesters valid → both readys=0 and out_data/out_id stable for 3 cycles. Raise out_ready → in that same cycle the prio requester gets ready=1; its result appears next cycle.
- Reset mid-operation: pull rst_n=0 while out_valid=1 & out_ready=0 → next edge out_valid=0, out_data=0, readys=0 during reset. After release, the first tie is granted to PRIO_RESET.
- Exhaustive sweep: all 128 (a, b, opt) combinations through each requester, compared against the mod-16 reference model. Include random out_ready and random valid patterns, and check no operation is lost or duplicated per requester.
